// File: rtl/matmul_pkg.sv
// Shared sizing, state encoding and C-bus indexing for the 4x4 matmul sequencer.
package matmul_pkg;

  localparam int unsigned N       = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned C_W     = N * N * ACC_W;
  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned C_OFF_W = $clog2(C_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit offset of element C[i][j] inside the packed result bus.
  function automatic logic [C_OFF_W-1:0] c_offset(input logic [IDX_W-1:0] i,
                                                  input logic [IDX_W-1:0] j);
    return C_OFF_W'((N * 32'(i) + 32'(j)) * ACC_W);
  endfunction

endpackage

// File: rtl/matmul_operand_store.sv
// Operand matrices A and B: reset-initialised to 1..N*N row-major, read combinationally.
module matmul_operand_store
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i,
  input  logic [IDX_W-1:0] j,
  input  logic [IDX_W-1:0] k,
  output logic [DW-1:0]    a_val_c,
  output logic [DW-1:0]    b_val_c
);

  logic [DW-1:0] a_mem [N][N];
  logic [DW-1:0] b_mem [N][N];

  // Load the fixed operand pattern on reset; contents hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          a_mem[r][c] <= DW'(r * N + c + 1);
          b_mem[r][c] <= DW'(r * N + c + 1);
        end
      end
    end else begin
      a_mem <= a_mem;
      b_mem <= b_mem;
    end
  end

  assign a_val_c = a_mem[i][k];
  assign b_val_c = b_mem[k][j];

endmodule

// File: rtl/matmul_fsm.sv
// Sequencer streaming A/B element pairs to an external MAC and collecting C = A*B.
module matmul_fsm
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ACC_W-1:0] mac_out_in_fsm,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic             enable_from_fsm,
  output logic [C_W-1:0]   C,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [IDX_W-1:0] i_d, j_d, k_d;
  logic [C_W-1:0]   c_d;
  logic [DW-1:0]    a_d, b_d;
  logic             enable_d;
  logic             done_d;
  logic [DW-1:0]    a_nxt_c, b_nxt_c;

  // Operands are looked up at the next-cycle indices so the outputs can be registered.
  matmul_operand_store u_store (
    .clk     (clk),
    .reset   (reset),
    .i       (i_d),
    .j       (j_d),
    .k       (k_d),
    .a_val_c (a_nxt_c),
    .b_val_c (b_nxt_c)
  );

  // State, counters, result bus and registered MAC-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      i_q             <= '0;
      j_q             <= '0;
      k_q             <= '0;
      C               <= '0;
      a_out           <= '0;
      b_out           <= '0;
      enable_from_fsm <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      i_q             <= i_d;
      j_q             <= j_d;
      k_q             <= k_d;
      C               <= c_d;
      a_out           <= a_d;
      b_out           <= b_d;
      enable_from_fsm <= enable_d;
      done            <= done_d;
    end
  end

  // Next-state, counter stepping, result capture and next output values.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    c_d      = C;
    a_d      = '0;
    b_d      = '0;
    enable_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          c_d     = '0;
        end
      end

      RUN: begin
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = CAPTURE;
        end else begin
          k_d = k_q + ONE;
        end
      end

      CAPTURE: begin
        c_d[c_offset(i_q, j_q) +: ACC_W] = mac_out_in_fsm;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d     = i_q + ONE;
            state_d = RUN;
          end
        end else begin
          j_d     = j_q + ONE;
          state_d = RUN;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // done asserts one cycle into DONE and drops on the edge that leaves it.
    enable_d = (state_d == RUN);
    done_d   = (state_q == DONE) && (state_d == DONE);
    if (enable_d) begin
      a_d = a_nxt_c;
      b_d = b_nxt_c;
    end
  end

endmodule

// File: tb/tb_matmul_fsm.sv
// Bench for matmul_fsm: behavioural MAC, timeline-based reference, randomized start/reset timing.
module tb_matmul_fsm;

  localparam int NN   = 4;
  localparam int AW   = 16;
  localparam int CW   = NN * NN * AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] mac_acc;
  logic [7:0]    a_out, b_out;
  logic          enable_from_fsm;
  logic [CW-1:0] C;
  logic          done;

  int      cyc     = 0;
  int      t0      = 0;
  bit      chk_run = 1'b0;
  int      checks  = 0;
  int      errors  = 0;
  logic [AW-1:0] exp_c [NN*NN];
  logic [CW-1:0] full_c;

  matmul_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mac_out_in_fsm  (mac_acc),
    .a_out           (a_out),
    .b_out           (b_out),
    .enable_from_fsm (enable_from_fsm),
    .C               (C),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External MAC as described by its contract.
  initial mac_acc = '0;
  always @(posedge clk) begin
    if (enable_from_fsm) mac_acc <= mac_acc + 16'(a_out) * 16'(b_out);
    else                 mac_acc <= '0;
  end

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Timeline reference: n cycles after the start-sampling edge, element n/5 at phase n%5.
  int            m_n, m_cnt, m_e, m_p;
  logic [CW-1:0] m_c;
  logic [7:0]    m_a, m_b;
  logic          m_en, m_done;
  always @(negedge clk) begin
    if (chk_run && reset) begin
      m_n = cyc - t0;
      if (m_n >= 0) begin
        m_cnt = (m_n >= 80) ? 16 : m_n / 5;
        m_c   = '0;
        for (int x = 0; x < NN*NN; x++) if (x < m_cnt) m_c[x*AW +: AW] = exp_c[x];
        m_a = '0; m_b = '0; m_en = 1'b0;
        if (m_n < 80 && (m_n % 5) < 4) begin
          m_e  = m_n / 5;
          m_p  = m_n % 5;
          m_en = 1'b1;
          m_a  = 8'((m_e / NN) * NN + m_p + 1);
          m_b  = 8'(m_p * NN + (m_e % NN) + 1);
        end
        m_done = (m_n >= 81);
        check("model_enable", CW'(enable_from_fsm), CW'(m_en));
        check("model_a", CW'(a_out), CW'(m_a));
        check("model_b", CW'(b_out), CW'(m_b));
        check("model_done", CW'(done), CW'(m_done));
        check("model_C", C, m_c);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_enable"}, CW'(enable_from_fsm), '0);
    check({tag, "_a"}, CW'(a_out), '0);
    check({tag, "_b"}, CW'(b_out), '0);
    check({tag, "_done"}, CW'(done), '0);
    check({tag, "_C"}, C, '0);
  endtask

  // Called at a negedge with the DUT idle and start low.
  task automatic start_run();
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    start   = 1'b1;
    t0      = cyc + 1;
    chk_run = 1'b1;
  endtask

  // Follows one run from the start edge through 20 DONE-hold cycles and the drop of start.
  task automatic run_body(input bit glitch, input bit first);
    int lit_a [5];
    int lit_b [5];
    int g_at, g_len;
    lit_a = '{1, 2, 3, 4, 0};
    lit_b = '{1, 5, 9, 13, 0};
    g_at  = $urandom_range(3, 60);
    g_len = $urandom_range(1, 3);
    for (int m = 0; m <= 100; m++) begin
      @(negedge clk);
      if (first && m < 5) begin
        check("lit_a", CW'(a_out), CW'(lit_a[m]));
        check("lit_b", CW'(b_out), CW'(lit_b[m]));
        check("lit_enable", CW'(enable_from_fsm), CW'(m < 4));
      end
      if (m == 80) check("done_not_yet", CW'(done), '0);
      if (m == 81) check("done_at_81", CW'(done), CW'(1));
      if (glitch) begin
        if (m == g_at)         start = 1'b0;
        if (m == g_at + g_len) start = 1'b1;
      end
    end
    check("lit_C00", CW'(C[0 +: AW]), CW'(90));
    check("lit_C01", CW'(C[AW +: AW]), CW'(100));
    check("lit_C33", CW'(C[15*AW +: AW]), CW'(600));
    check("full_C", C, full_c);
    chk_run = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    check("idle_done", CW'(done), '0);
    check("idle_enable", CW'(enable_from_fsm), '0);
    check("idle_C_held", C, full_c);
    @(negedge clk);
  endtask

  task automatic reset_mid_run(input int at_n);
    start_run();
    repeat (at_n + 1) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    chk_run = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    reset   = 1'b1;
    t0      = cyc + 1;
    chk_run = 1'b1;
    run_body(1'b0, 1'b0);
  endtask

  initial begin
    int s;
    full_c = '0;
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        s = 0;
        for (int k = 0; k < NN; k++) s += (i*NN + k + 1) * (k*NN + j + 1);
        exp_c[i*NN + j] = 16'(s);
        full_c[(i*NN + j)*AW +: AW] = 16'(s);
      end
    end

    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset   = 1'b1;
    t0      = cyc + 1;
    chk_run = 1'b1;
    run_body(1'b0, 1'b1);

    start_run();
    run_body(1'b0, 1'b0);

    start_run();
    run_body(1'b1, 1'b0);

    reset_mid_run(37);
    reset_mid_run($urandom_range(1, 79));

    start_run();
    run_body(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
